estagio_writeback: RTL and testbench
====================================

Name: estagio_writeback

Overview:
- Final pipeline stage; sits directly upstream of the register bank and drives its write port (reg_escrita, endereco_regd, dado_escrita).
- Accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake and holds it in a single-entry pipeline register.
- Selects the writeback source and performs load byte/half extraction with sign/zero extension.
- Detects misaligned loads, exports a same-cycle forwarding path for decode, and counts retired instructions.

Parameters:
- LARGURA_DADOS, 32, data width of results and register bank words.
- NUM_REGS, 32, register count; address width = clog2(NUM_REGS) = 5.
- LARGURA_CONTADOR, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- entrada_valida  in  1  memory stage presents an instruction.
- entrada_pronta  out  1  stage accepts this cycle.
- congela  in  1  freeze request: blocks acceptance of new instructions.
- ent_escreve  in  1  instruction writes rd.
- ent_regd  in  5  destination register.
- ent_fonte  in  2  source select: 0 ULA, 1 memoria, 2 pc_mais4, 3 imediato.
- ent_resultado_ula  in  32  ALU result; also the load byte address.
- ent_dado_mem  in  32  raw aligned data-memory word.
- ent_tipo_load  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ent_pc_mais4  in  32  link value.
- ent_imediato  in  32  LUI value.
- reg_escrita  out  1  register-bank write enable.
- endereco_regd  out  5  register-bank write address.
- dado_escrita  out  32  register-bank write data.
- fwd_valido, fwd_regd, fwd_dado  out  1/5/32  forwarding copy of the write port.
- erro_alinhamento  out  1  one-cycle pulse: misaligned load dropped.
- endereco_erro  out  32  faulting address; held until the next error.
- instret  out  64  retired-instruction count.

Behaviour:
- Handshake:
  - entrada_pronta = !congela && !reset.
  - Transfer occurs when entrada_valida && entrada_pronta at a rising edge.
  - The stage never back-pressures for any other reason.
- Slot register:
  - On transfer, capture the computed result, rd, write flag, and alignment check; slot_valido <= 1.
  - With no transfer, slot_valido <= 0. Each instruction occupies the slot exactly one cycle, so no write repeats.
- Latency: accept at edge N, outputs valid during cycle N+1, register bank writes at edge N+1.
- Data selection (computed before capture):
  - fonte 0 gives ent_resultado_ula; 2 gives ent_pc_mais4; 3 gives ent_imediato.
  - fonte 1 extracts from ent_dado_mem using offset = ent_resultado_ula[1:0]:
    - LB/LBU: byte at offset*8, sign- or zero-extended.
    - LH/LHU: half at offset[1]*16, extended.
    - LW: full word.
    - Undefined tipo codes return the full word.
- Alignment:
  - Misaligned cases: LH/LHU with offset[0]=1; LW with offset≠0. Checked only when fonte=1.
  - Misaligned load: reg_escrita=0 for that slot; erro_alinhamento=1 for that cycle; endereco_erro <= ent_resultado_ula; instret still increments (instruction retired as a trap).
- Write port:
  - reg_escrita = slot_valido && slot_escreve && slot_regd≠0 && !slot_erro.
  - endereco_regd/dado_escrita always reflect the slot; don't-care when reg_escrita=0.
- Forwarding: fwd_valido = reg_escrita; fwd_regd/fwd_dado = endereco_regd/dado_escrita. Combinational from the slot.
- Counter: instret increments by 1 each cycle slot_valido=1 and wraps modulo 2^64.
- Reset:
  - slot_valido=0, reg_escrita=0, fwd_valido=0, erro_alinhamento=0, endereco_erro=0, instret=0.
  - Reset mid-operation discards the slot; no write occurs in the cycle after reset.
- Simultaneous events:
  - congela=1 while the slot is valid: the slot still writes and retires, and nothing new is accepted.
  - Transfer and slot write in the same cycle: both proceed (full throughput).

Decomposition:
- Pacote_pipeline package holds:
  - The FONTE_* enum (ULA=0, MEM=1, PC4=2, IMM=3).
  - The funct3 load constants (LB, LH, LW, LBU, LHU).
  - LARGURA_DADOS and the register address width.
- One sub-module: extrator_load, purely combinational. Inputs word, offset, and tipo; outputs extended data and a misaligned flag.
- Slot, counter and error capture stay in the top module.

Test Plan:
- ALU write: valid, fonte=0, rd=5, ULA=0x0000_1234 -> next cycle reg_escrita=1, endereco_regd=5, dado_escrita=0x1234, instret=1.
- Load extension:
  - mem=0x80FF_7F01, LB offset=2 -> 0xFFFF_FFFF.
  - LBU offset=3 -> 0x0000_0080.
  - LH offset=2 -> 0xFFFF_80FF.
- Misaligned LW, ULA=0x0000_1002, rd=7 -> reg_escrita=0, erro_alinhamento pulse 1 cycle, endereco_erro=0x1002, instret increments.
- rd=0 with escreve=1, ULA=0xDEAD_BEEF -> reg_escrita=0, instret increments.
- Back-to-back 4 instructions, then congela=1 for 3 cycles with entrada_valida=1:
  - 4 consecutive writes in consecutive cycles.
  - entrada_pronta=0 for the 3 frozen cycles, with no write in the cycles after the last one.
  - Acceptance resumes when congela=0.
- Reset asserted the cycle after accepting rd=9 -> no write to x9; all outputs at reset values; instret=0.

Source files
------------

// File: rtl/estagio_writeback_pkg.sv
// rtl/estagio_writeback_pkg.sv - shared types and constants for the writeback stage
package estagio_writeback_pkg;

    localparam int LARGURA_DADOS   = 32;
    localparam int LARGURA_END_REG = 5;

    typedef enum logic [1:0] {
        FONTE_ULA = 2'd0,
        FONTE_MEM = 2'd1,
        FONTE_PC4 = 2'd2,
        FONTE_IMM = 2'd3
    } fonte_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/estagio_writeback_extrator_load.sv
// rtl/estagio_writeback_extrator_load.sv - load byte/half extraction, extension and alignment check
module extrator_load
    import estagio_writeback_pkg::*;
(
    input  logic [LARGURA_DADOS-1:0] palavra,
    input  logic [1:0]               deslocamento,
    input  logic [2:0]               tipo,
    output logic [LARGURA_DADOS-1:0] dado,
    output logic                     desalinhado
);

    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;

    assign byte_sel = palavra[{deslocamento, 3'b000} +: 8];
    assign meia_sel = palavra[{deslocamento[1], 4'b0000} +: 16];

    always_comb begin
        dado        = palavra;
        desalinhado = 1'b0;
        case (tipo)
            LOAD_LB:  dado = {{(LARGURA_DADOS-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: dado = {{(LARGURA_DADOS-8){1'b0}}, byte_sel};
            LOAD_LH: begin
                dado        = {{(LARGURA_DADOS-16){meia_sel[15]}}, meia_sel};
                desalinhado = deslocamento[0];
            end
            LOAD_LHU: begin
                dado        = {{(LARGURA_DADOS-16){1'b0}}, meia_sel};
                desalinhado = deslocamento[0];
            end
            LOAD_LW:  desalinhado = (deslocamento != 2'b00);
            // Undefined funct3 codes fall back to the raw word with no trap
            default:  dado = palavra;
        endcase
    end

endmodule

// File: rtl/estagio_writeback.sv
// rtl/estagio_writeback.sv - final pipeline stage driving the register bank write port
module estagio_writeback #(
    parameter int LARGURA_DADOS    = 32,
    parameter int NUM_REGS         = 32,
    parameter int LARGURA_CONTADOR = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        entrada_valida,
    output logic                        entrada_pronta,
    input  logic                        congela,
    input  logic                        ent_escreve,
    input  logic [$clog2(NUM_REGS)-1:0] ent_regd,
    input  logic [1:0]                  ent_fonte,
    input  logic [LARGURA_DADOS-1:0]    ent_resultado_ula,
    input  logic [LARGURA_DADOS-1:0]    ent_dado_mem,
    input  logic [2:0]                  ent_tipo_load,
    input  logic [LARGURA_DADOS-1:0]    ent_pc_mais4,
    input  logic [LARGURA_DADOS-1:0]    ent_imediato,
    output logic                        reg_escrita,
    output logic [$clog2(NUM_REGS)-1:0] endereco_regd,
    output logic [LARGURA_DADOS-1:0]    dado_escrita,
    output logic                        fwd_valido,
    output logic [$clog2(NUM_REGS)-1:0] fwd_regd,
    output logic [LARGURA_DADOS-1:0]    fwd_dado,
    output logic                        erro_alinhamento,
    output logic [LARGURA_DADOS-1:0]    endereco_erro,
    output logic [LARGURA_CONTADOR-1:0] instret
);

    import estagio_writeback_pkg::*;

    localparam int LARGURA_REG = $clog2(NUM_REGS);

    logic                     transferencia;
    logic                     desalinhado;
    logic                     erro_ent;
    logic [LARGURA_DADOS-1:0] dado_load;
    logic [LARGURA_DADOS-1:0] dado_sel;

    logic                     slot_valido;
    logic                     slot_escreve;
    logic                     slot_erro;
    logic [LARGURA_REG-1:0]   slot_regd;
    logic [LARGURA_DADOS-1:0] slot_dado;

    assign entrada_pronta = !congela && !reset;
    assign transferencia  = entrada_valida && entrada_pronta;

    extrator_load u_extrator (
        .palavra      (ent_dado_mem),
        .deslocamento (ent_resultado_ula[1:0]),
        .tipo         (ent_tipo_load),
        .dado         (dado_load),
        .desalinhado  (desalinhado)
    );

    always_comb begin
        dado_sel = ent_resultado_ula;
        case (ent_fonte)
            FONTE_ULA: dado_sel = ent_resultado_ula;
            FONTE_MEM: dado_sel = dado_load;
            FONTE_PC4: dado_sel = ent_pc_mais4;
            FONTE_IMM: dado_sel = ent_imediato;
            default:   dado_sel = ent_resultado_ula;
        endcase
    end

    assign erro_ent = (ent_fonte == FONTE_MEM) && desalinhado;

    // instret counts on acceptance, so during the slot cycle it already includes that instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valido   <= 1'b0;
            slot_escreve  <= 1'b0;
            slot_erro     <= 1'b0;
            slot_regd     <= '0;
            slot_dado     <= '0;
            endereco_erro <= '0;
            instret       <= '0;
        end else begin
            slot_valido <= transferencia;
            if (transferencia) begin
                slot_escreve <= ent_escreve;
                slot_erro    <= erro_ent;
                slot_regd    <= ent_regd;
                slot_dado    <= dado_sel;
                instret      <= instret + LARGURA_CONTADOR'(1);
                if (erro_ent) begin
                    endereco_erro <= ent_resultado_ula;
                end
            end
        end
    end

    // Gating with reset discards a slot caught by a mid-operation reset
    assign reg_escrita      = slot_valido && slot_escreve && (slot_regd != '0) && !slot_erro && !reset;
    assign erro_alinhamento = slot_valido && slot_erro && !reset;
    assign endereco_regd    = slot_regd;
    assign dado_escrita     = slot_dado;

    assign fwd_valido = reg_escrita;
    assign fwd_regd   = endereco_regd;
    assign fwd_dado   = dado_escrita;

endmodule

// File: tb/tb_estagio_writeback.sv
// tb/tb_estagio_writeback.sv - scoreboard bench for estagio_writeback
module tb_estagio_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic        congela;
    logic        ent_escreve;
    logic [4:0]  ent_regd;
    logic [1:0]  ent_fonte;
    logic [31:0] ent_resultado_ula;
    logic [31:0] ent_dado_mem;
    logic [2:0]  ent_tipo_load;
    logic [31:0] ent_pc_mais4;
    logic [31:0] ent_imediato;
    logic        reg_escrita;
    logic [4:0]  endereco_regd;
    logic [31:0] dado_escrita;
    logic        fwd_valido;
    logic [4:0]  fwd_regd;
    logic [31:0] fwd_dado;
    logic        erro_alinhamento;
    logic [31:0] endereco_erro;
    logic [63:0] instret;

    estagio_writeback dut (
        .clock             (clock),
        .reset             (reset),
        .entrada_valida    (entrada_valida),
        .entrada_pronta    (entrada_pronta),
        .congela           (congela),
        .ent_escreve       (ent_escreve),
        .ent_regd          (ent_regd),
        .ent_fonte         (ent_fonte),
        .ent_resultado_ula (ent_resultado_ula),
        .ent_dado_mem      (ent_dado_mem),
        .ent_tipo_load     (ent_tipo_load),
        .ent_pc_mais4      (ent_pc_mais4),
        .ent_imediato      (ent_imediato),
        .reg_escrita       (reg_escrita),
        .endereco_regd     (endereco_regd),
        .dado_escrita      (dado_escrita),
        .fwd_valido        (fwd_valido),
        .fwd_regd          (fwd_regd),
        .fwd_dado          (fwd_dado),
        .erro_alinhamento  (erro_alinhamento),
        .endereco_erro     (endereco_erro),
        .instret           (instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          w;
        bit          e;
        logic [4:0]  rd;
        logic [31:0] dado;
        logic [31:0] addr;
        logic [63:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 0;
    logic [63:0] acc_cnt = 0;
    logic [63:0] vis_cnt = 0;
    logic [31:0] vis_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nome, act, req, cyc);
        end
    endtask

    // Reference: load semantics from plain arithmetic on byte offsets
    function automatic void ref_model(input logic [1:0] f, input logic [31:0] ula, input logic [31:0] mem,
                                      input logic [2:0] tipo, input logic [31:0] pc4, input logic [31:0] imm,
                                      output logic [31:0] d, output bit e);
        longint b, h;
        int off;
        off = int'(ula % 4);
        b = longint'((mem >> (8 * off)) % 256);
        h = longint'((mem >> (16 * (off / 2))) % 65536);
        e = 0;
        d = mem;
        case (f)
            2'd0: d = ula;
            2'd2: d = pc4;
            2'd3: d = imm;
            default: begin
                case (tipo)
                    3'b000: d = 32'((b >= 128) ? b - 256 : b);
                    3'b100: d = 32'(b);
                    3'b001: begin d = 32'((h >= 32768) ? h - 65536 : h); e = (off % 2) != 0; end
                    3'b101: begin d = 32'(h); e = (off % 2) != 0; end
                    3'b010: begin d = mem; e = off != 0; end
                    default: d = mem;
                endcase
            end
        endcase
    endfunction

    task automatic send(input bit v, input bit c, input bit r, input bit esc, input logic [4:0] rd,
                        input logic [1:0] f, input logic [31:0] ula, input logic [31:0] mem,
                        input logic [2:0] tipo, input logic [31:0] pc4, input logic [31:0] imm);
        exp_t it;
        logic [31:0] d;
        bit e;
        @(posedge clock);
        #1;
        reset = r; entrada_valida = v; congela = c; ent_escreve = esc; ent_regd = rd;
        ent_fonte = f; ent_resultado_ula = ula; ent_dado_mem = mem; ent_tipo_load = tipo;
        ent_pc_mais4 = pc4; ent_imediato = imm;
        if (r) acc_cnt = 0;
        if (v && !c && !r) begin
            ref_model(f, ula, mem, tipo, pc4, imm, d, e);
            acc_cnt++;
            it.due = cyc + 1; it.w = esc && (rd != 0) && !e; it.e = e; it.rd = rd;
            it.dado = d; it.addr = ula; it.cnt = acc_cnt;
            q.push_back(it);
        end
    endtask

    task automatic idle();
        send(0, 0, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            exp_t it;
            bit ew, ee;
            chk("entrada_pronta", entrada_pronta, !congela && !reset);
            if (reset) begin
                chk("reset_reg_escrita", reg_escrita, 0);
                chk("reset_erro", erro_alinhamento, 0);
                while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
                vis_cnt = 0;
                vis_err = 0;
            end else begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    chk("missed_retire_due", q[0].due, cyc);
                    void'(q.pop_front());
                end
                ew = 0; ee = 0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    it = q.pop_front();
                    ew = it.w; ee = it.e; vis_cnt = it.cnt;
                    if (it.e) vis_err = it.addr;
                    if (it.w) begin
                        chk("endereco_regd", endereco_regd, it.rd);
                        chk("dado_escrita", dado_escrita, it.dado);
                        chk("fwd_regd", fwd_regd, it.rd);
                        chk("fwd_dado", fwd_dado, it.dado);
                    end
                end
                chk("reg_escrita", reg_escrita, ew);
                chk("fwd_valido", fwd_valido, ew);
                chk("erro_alinhamento", erro_alinhamento, ee);
                chk("endereco_erro", endereco_erro, vis_err);
                chk("instret", instret, vis_cnt);
            end
        end
    end

    initial begin
        reset = 1; entrada_valida = 0; congela = 0; ent_escreve = 0; ent_regd = 0; ent_fonte = 0;
        ent_resultado_ula = 0; ent_dado_mem = 0; ent_tipo_load = 0; ent_pc_mais4 = 0; ent_imediato = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        mon_en = 1;
        idle();

        send(1, 0, 0, 1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 3'd0, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd1, 2'd1, 32'h0000_0102, 32'h80FF_7F01, 3'b000, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd2, 2'd1, 32'h0000_0103, 32'h80FF_7F01, 3'b100, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd3, 2'd1, 32'h0000_0102, 32'h80FF_7F01, 3'b001, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd7, 2'd1, 32'h0000_1002, 32'h1234_5678, 3'b010, 32'h0, 32'h0);
        idle();
        send(1, 0, 0, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd10, 2'd2, 32'h0, 32'h0, 3'd0, 32'h0000_0044, 32'h0);
        send(1, 0, 0, 1, 5'd11, 2'd3, 32'h0, 32'h0, 3'd0, 32'h0, 32'hABCD_E000);
        send(1, 0, 0, 1, 5'd12, 2'd1, 32'h0000_0006, 32'h1357_9BDF, 3'b101, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd13, 2'd0, 32'h0000_0013, 32'h0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            send(1, 1, 0, 1, 5'd20, 2'd0, 32'hFFFF_0000, 32'h0, 3'd0, 32'h0, 32'h0);
        send(1, 0, 0, 1, 5'd14, 2'd0, 32'h0000_0099, 32'h0, 3'd0, 32'h0, 32'h0);
        idle();

        send(1, 0, 0, 1, 5'd9, 2'd0, 32'h0000_0009, 32'h0, 3'd0, 32'h0, 32'h0);
        send(1, 0, 1, 1, 5'd9, 2'd0, 32'h0000_0009, 32'h0, 3'd0, 32'h0, 32'h0);
        idle();
        idle();

        for (int i = 0; i < 400; i++) begin
            send(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 80) == 0, ($urandom % 4) != 0,
                 5'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom, $urandom);
        end
        idle();
        idle();
        idle();
        @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
